// File: rtl/qid_desc_consumer.sv
// Consumer end of the per-queue scheduling interface: takes one granted queue ID,
// issues up to BURST_MAX packet requests with matching descriptor decrements, then requeues it.
module qid_desc_consumer #(
  parameter int QUEUE_ID_WIDTH = 7,
  parameter int DESC_CNT_WIDTH = 16,
  parameter int BURST_MAX      = 8,
  parameter int DEC_SETTLE     = 2,
  parameter int TCQ            = 1
) (
  input  logic                      user_clk,
  input  logic                      user_reset_n,
  input  logic                      enable,
  input  logic                      qid_vld,
  input  logic [QUEUE_ID_WIDTH-1:0] qid,
  input  logic [DESC_CNT_WIDTH-1:0] qid_desc_avail,
  output logic                      qid_rdy,
  output logic                      pkt_req_vld,
  output logic [QUEUE_ID_WIDTH-1:0] pkt_req_qid,
  output logic                      pkt_req_last,
  input  logic                      pkt_req_rdy,
  output logic                      desc_cnt_dec,
  output logic [QUEUE_ID_WIDTH-1:0] desc_cnt_dec_qid,
  output logic                      requeue_vld,
  output logic [QUEUE_ID_WIDTH-1:0] requeue_qid,
  input  logic                      requeue_rdy,
  output logic                      busy
);

  localparam int SettleW = (DEC_SETTLE < 2) ? 1 : $clog2(DEC_SETTLE + 1);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'((DEC_SETTLE > 0) ? DEC_SETTLE - 1 : 0);
  localparam logic [SettleW-1:0] SettleOne  = SettleW'(1);
  localparam logic [DESC_CNT_WIDTH-1:0] BurstMaxC = DESC_CNT_WIDTH'(BURST_MAX);
  localparam logic [DESC_CNT_WIDTH-1:0] CntOne    = DESC_CNT_WIDTH'(1);
  localparam logic [DESC_CNT_WIDTH-1:0] CntTwo    = DESC_CNT_WIDTH'(2);

  // TCQ only matters to delay-annotated simulation models; this RTL adds none.
  if (TCQ < 0) begin : g_tcq_unused
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE,
    REQUEUE
  } state_t;

  state_t                    state_q;
  logic [QUEUE_ID_WIDTH-1:0] curQid_q;
  logic [DESC_CNT_WIDTH-1:0] remaining_q;
  logic [DESC_CNT_WIDTH-1:0] grantCnt_d;
  logic [SettleW-1:0]        settleCnt_q;
  logic                      pktReqVld_q;
  logic                      pktReqLast_q;
  logic                      descCntDec_q;
  logic                      requeueVld_q;
  logic                      grantFire;
  logic                      pktFire;
  logic                      rqFire;

  // Reset is folded in so that no output reads high while reset is held.
  assign qid_rdy    = (state_q == IDLE) & enable & user_reset_n;
  assign grantFire  = qid_vld & qid_rdy;
  assign pktFire    = pktReqVld_q & pkt_req_rdy;
  assign rqFire     = requeueVld_q & requeue_rdy;
  assign grantCnt_d = (qid_desc_avail > BurstMaxC) ? BurstMaxC : qid_desc_avail;

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q      <= IDLE;
      curQid_q     <= '0;
      remaining_q  <= '0;
      settleCnt_q  <= '0;
      pktReqVld_q  <= 1'b0;
      pktReqLast_q <= 1'b0;
      descCntDec_q <= 1'b0;
      requeueVld_q <= 1'b0;
    end else begin
      descCntDec_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantFire) begin
            curQid_q    <= qid;
            remaining_q <= grantCnt_d;
            if (grantCnt_d == '0) begin
              state_q      <= REQUEUE;
              requeueVld_q <= 1'b1;
            end else begin
              state_q      <= ISSUE;
              pktReqVld_q  <= 1'b1;
              pktReqLast_q <= (grantCnt_d == CntOne);
            end
          end
        end
        ISSUE: begin
          if (pktFire) begin
            descCntDec_q <= 1'b1;
            remaining_q  <= remaining_q - CntOne;
            if (remaining_q == CntOne) begin
              pktReqVld_q  <= 1'b0;
              pktReqLast_q <= 1'b0;
              if (DEC_SETTLE == 0) begin
                state_q      <= REQUEUE;
                requeueVld_q <= 1'b1;
              end else begin
                state_q     <= SETTLE;
                settleCnt_q <= SettleLoad;
              end
            end else begin
              pktReqLast_q <= (remaining_q == CntTwo);
            end
          end
        end
        // Gives the scheduler time to absorb the last decrement before the ID returns.
        SETTLE: begin
          if (settleCnt_q == '0) begin
            state_q      <= REQUEUE;
            requeueVld_q <= 1'b1;
          end else begin
            settleCnt_q <= settleCnt_q - SettleOne;
          end
        end
        REQUEUE: begin
          if (rqFire) begin
            state_q      <= IDLE;
            requeueVld_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pkt_req_vld      = pktReqVld_q;
  assign pkt_req_qid      = curQid_q;
  assign pkt_req_last     = pktReqLast_q;
  assign desc_cnt_dec     = descCntDec_q;
  assign desc_cnt_dec_qid = curQid_q;
  assign requeue_vld      = requeueVld_q;
  assign requeue_qid      = curQid_q;
  assign busy             = (state_q != IDLE);

endmodule
